// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU and the AES DMA port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        eOwnNone,
        eOwnCpu,
        eOwnAes
    } rd_owner_e;

    localparam int STARVE_W = 4;
    localparam int STAT_W   = 16;

endpackage

// File: rtl/dmem_arb_if.sv
// One requester's access channel into the data-memory arbiter; signal suffixes are from the arbiter's side.
interface dmem_arb_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req_v_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              ready_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;

    modport master (
        output req_v_i, we_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_v_i, we_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/dmem_arb_stats.sv
// Wrapping grant/contention counters for the data-memory arbiter (built only with DMEM_ARB_STATS_EN).
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              cpu_acc_i,
    input  logic              aes_acc_i,
    input  logic              conflict_i,
    output logic [STAT_W-1:0] stat_cpu_grants_o,
    output logic [STAT_W-1:0] stat_aes_grants_o,
    output logic [STAT_W-1:0] stat_conflicts_o
);
    logic [STAT_W-1:0] cpu_cnt_q, aes_cnt_q, conf_cnt_q;
    logic [STAT_W-1:0] cpu_cnt_d, aes_cnt_d, conf_cnt_d;

    always_comb begin
        cpu_cnt_d  = cpu_cnt_q  + STAT_W'(cpu_acc_i);
        aes_cnt_d  = aes_cnt_q  + STAT_W'(aes_acc_i);
        conf_cnt_d = conf_cnt_q + STAT_W'(conflict_i);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cpu_cnt_q  <= '0;
            aes_cnt_q  <= '0;
            conf_cnt_q <= '0;
        end else begin
            cpu_cnt_q  <= cpu_cnt_d;
            aes_cnt_q  <= aes_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign stat_cpu_grants_o = cpu_cnt_q;
    assign stat_aes_grants_o = aes_cnt_q;
    assign stat_conflicts_o  = conf_cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU fixed priority with an AES starvation override; routes 1-cycle read data.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_n,
    dmem_arb_if.slave         cpu,
    dmem_arb_if.slave         aes,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_d_o,
    input  logic [DATA_W-1:0] mem_q_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cpu_grants_o,
    output logic [STAT_W-1:0] stat_aes_grants_o,
    output logic [STAT_W-1:0] stat_conflicts_o
`endif
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] aes_wait_q, aes_wait_d;
    rd_owner_e           rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   cpu_rdata_q, aes_rdata_q;
    logic                starved, cpu_acc, aes_acc;

    // Accepts are gated by reset_n so nothing is granted while reset is held.
    always_comb begin
        starved    = (aes_wait_q == STARVE_LIM);
        aes_acc    = reset_n & aes.req_v_i & (~cpu.req_v_i | starved);
        cpu_acc    = reset_n & cpu.req_v_i & ~aes_acc;

        mem_wen_o  = (cpu_acc & cpu.we_i) | (aes_acc & aes.we_i);
        mem_addr_o = aes_acc ? aes.addr_i : (cpu_acc ? cpu.addr_i : mem_addr_q);
        mem_d_o    = aes_acc ? aes.wdata_i : cpu.wdata_i;

        aes_wait_d = aes_wait_q;
        if (aes_acc)
            aes_wait_d = '0;
        else if (aes.req_v_i && !starved)
            aes_wait_d = aes_wait_q + STARVE_W'(1);

        rd_owner_d = eOwnNone;
        if (cpu_acc && !cpu.we_i)
            rd_owner_d = eOwnCpu;
        else if (aes_acc && !aes.we_i)
            rd_owner_d = eOwnAes;
    end

    assign cpu.ready_o  = cpu_acc;
    assign aes.ready_o  = aes_acc;
    assign cpu.rvalid_o = (rd_owner_q == eOwnCpu);
    assign aes.rvalid_o = (rd_owner_q == eOwnAes);
    // Read data is passed straight through in the return cycle and held afterwards.
    assign cpu.rdata_o  = cpu.rvalid_o ? mem_q_i : cpu_rdata_q;
    assign aes.rdata_o  = aes.rvalid_o ? mem_q_i : aes_rdata_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            aes_wait_q  <= '0;
            rd_owner_q  <= eOwnNone;
            mem_addr_q  <= '0;
            cpu_rdata_q <= '0;
            aes_rdata_q <= '0;
        end else begin
            aes_wait_q <= aes_wait_d;
            rd_owner_q <= rd_owner_d;
            mem_addr_q <= mem_addr_o;
            if (cpu.rvalid_o)
                cpu_rdata_q <= mem_q_i;
            if (aes.rvalid_o)
                aes_rdata_q <= mem_q_i;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk_i             (clk_i),
        .reset_n           (reset_n),
        .cpu_acc_i         (cpu_acc),
        .aes_acc_i         (aes_acc),
        .conflict_i        (cpu.req_v_i & aes.req_v_i),
        .stat_cpu_grants_o (stat_cpu_grants_o),
        .stat_aes_grants_o (stat_aes_grants_o),
        .stat_conflicts_o  (stat_conflicts_o)
    );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency data memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int                n_tests = 0;
    int                n_fail  = 0;
`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] st_cpu, st_aes, st_conf;
`endif

    dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
    dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) aes_if ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk_i      (clk),
        .reset_n    (reset_n),
        .cpu        (cpu_if.slave),
        .aes        (aes_if.slave),
        .mem_wen_o  (mem_wen),
        .mem_addr_o (mem_addr),
        .mem_d_o    (mem_d),
        .mem_q_i    (mem_q)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_grants_o (st_cpu),
        .stat_aes_grants_o (st_aes),
        .stat_conflicts_o  (st_conf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_d;
        mem_q <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_if.req_v_i = 1'b0; cpu_if.we_i = 1'b0; cpu_if.addr_i = '0; cpu_if.wdata_i = '0;
        aes_if.req_v_i = 1'b0; aes_if.we_i = 1'b0; aes_if.addr_i = '0; aes_if.wdata_i = '0;
    endtask

    task automatic cpu_drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_if.req_v_i = 1'b1; cpu_if.we_i = we; cpu_if.addr_i = a; cpu_if.wdata_i = d;
    endtask

    task automatic aes_drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        aes_if.req_v_i = 1'b1; aes_if.we_i = we; aes_if.addr_i = a; aes_if.wdata_i = d;
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        idle_all();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_aes;
        logic [5:0] exp_hold;
        exp_aes  = 10'b10000_10000;
        exp_hold = 6'b100000;

        reset_n = 1'b0;
        idle_all();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[9'h010] = 16'hBEEF;
        mem[9'h001] = 16'h1111;
        mem[9'h002] = 16'h2222;

        // Reset state, with a CPU request held during reset
        repeat (2) @(posedge clk);
        #1;
        cpu_drive(1'b0, 9'h010, '0);
        #1;
        chk("rst_cpu_ready", cpu_if.ready_o, 0);
        chk("rst_aes_ready", aes_if.ready_o, 0);
        chk("rst_cpu_rvalid", cpu_if.rvalid_o, 0);
        chk("rst_aes_rvalid", aes_if.rvalid_o, 0);
        chk("rst_cpu_rdata", cpu_if.rdata_o, 0);
        chk("rst_aes_rdata", aes_if.rdata_o, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        idle_all();
        @(negedge clk);
        reset_n = 1'b1;

        // 1: CPU-only read
        step();
        cpu_drive(1'b0, 9'h010, '0);
        #1;
        chk("s1_cpu_ready", cpu_if.ready_o, 1);
        chk("s1_aes_ready", aes_if.ready_o, 0);
        chk("s1_addr", mem_addr, 9'h010);
        chk("s1_wen", mem_wen, 0);
        step();
        idle_all();
        #1;
        chk("s1_cpu_rvalid", cpu_if.rvalid_o, 1);
        chk("s1_cpu_rdata", cpu_if.rdata_o, 16'hBEEF);
        chk("s1_aes_rvalid", aes_if.rvalid_o, 0);
        step();
        #1;
        chk("s1_cpu_rvalid_off", cpu_if.rvalid_o, 0);
        chk("s1_cpu_rdata_hold", cpu_if.rdata_o, 16'hBEEF);
        chk("s1_addr_hold", mem_addr, 9'h010);

        // 2: AES-only write
        step();
        aes_drive(1'b1, 9'h1F0, 16'h1234);
        #1;
        chk("s2_aes_ready", aes_if.ready_o, 1);
        chk("s2_wen", mem_wen, 1);
        chk("s2_addr", mem_addr, 9'h1F0);
        chk("s2_d", mem_d, 16'h1234);
        step();
        idle_all();
        #1;
        chk("s2_aes_rvalid", aes_if.rvalid_o, 0);
        chk("s2_cpu_rvalid", cpu_if.rvalid_o, 0);
        chk("s2_wen_off", mem_wen, 0);
        chk("s2_mem_written", mem[9'h1F0], 16'h1234);

        // 3: continuous contention, pattern C,C,C,C,A
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            cpu_drive(1'b1, 9'h020, 16'h00C0);
            aes_drive(1'b1, 9'h021, 16'h00A0);
            #1;
            chk($sformatf("s3_aes_ready_%0d", i), aes_if.ready_o, exp_aes[i]);
            chk($sformatf("s3_cpu_ready_%0d", i), cpu_if.ready_o, !exp_aes[i]);
            chk($sformatf("s3_addr_%0d", i), mem_addr, exp_aes[i] ? 9'h021 : 9'h020);
        end
        step();
`ifdef DMEM_ARB_STATS_EN
        chk("s6_cpu_grants", st_cpu, 8);
        chk("s6_aes_grants", st_aes, 2);
        chk("s6_conflicts", st_conf, 10);
`endif
        // Wait count holds while AES drops its request for one cycle
        for (int j = 0; j < 6; j++) begin
            if (j > 0) step();
            aes_if.req_v_i = (j != 2);
            #1;
            chk($sformatf("hold_aes_ready_%0d", j), aes_if.ready_o, exp_hold[j]);
            chk($sformatf("hold_cpu_ready_%0d", j), cpu_if.ready_o, !exp_hold[j]);
        end
        step();
        idle_all();

        // 4: alternating reads CPU then AES
        step();
        cpu_drive(1'b0, 9'h001, '0);
        #1;
        chk("s4_cpu_ready", cpu_if.ready_o, 1);
        step();
        idle_all();
        aes_drive(1'b0, 9'h002, '0);
        #1;
        chk("s4_aes_ready", aes_if.ready_o, 1);
        chk("s4_cpu_rvalid", cpu_if.rvalid_o, 1);
        chk("s4_cpu_rdata", cpu_if.rdata_o, 16'h1111);
        chk("s4_aes_rvalid_early", aes_if.rvalid_o, 0);
        step();
        idle_all();
        #1;
        chk("s4_aes_rvalid", aes_if.rvalid_o, 1);
        chk("s4_aes_rdata", aes_if.rdata_o, 16'h2222);
        chk("s4_cpu_rvalid_off", cpu_if.rvalid_o, 0);

        // Write accepted right after a read leaves the read return intact
        step();
        cpu_drive(1'b0, 9'h010, '0);
        step();
        idle_all();
        aes_drive(1'b1, 9'h003, 16'hCAFE);
        #1;
        chk("rw_cpu_rvalid", cpu_if.rvalid_o, 1);
        chk("rw_cpu_rdata", cpu_if.rdata_o, 16'hBEEF);
        chk("rw_wen", mem_wen, 1);
        step();
        idle_all();
        #1;
        chk("rw_aes_rvalid", aes_if.rvalid_o, 0);
        chk("rw_aes_rdata_hold", aes_if.rdata_o, 16'h2222);
        chk("rw_mem", mem[9'h003], 16'hCAFE);

        // 5: reset while a CPU read is in flight
        step();
        cpu_drive(1'b0, 9'h010, '0);
        #1;
        chk("s5_cpu_ready", cpu_if.ready_o, 1);
        step();
        idle_all();
        reset_n = 1'b0;
        #1;
        chk("s5_cpu_rvalid_drop", cpu_if.rvalid_o, 0);
        chk("s5_cpu_rdata_clr", cpu_if.rdata_o, 0);
        step();
        chk("s5_cpu_rvalid_stay", cpu_if.rvalid_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("s5_aes_rdata", aes_if.rdata_o, 0);
        chk("s5_wen", mem_wen, 0);
        chk("s5_addr", mem_addr, 0);
        chk("s5_cpu_rvalid_rel", cpu_if.rvalid_o, 0);
        step();
        cpu_drive(1'b0, 9'h001, '0);
        #1;
        chk("s5_new_ready", cpu_if.ready_o, 1);
        step();
        idle_all();
        #1;
        chk("s5_new_rvalid", cpu_if.rvalid_o, 1);
        chk("s5_new_rdata", cpu_if.rdata_o, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
